sys_array_tile_scheduler: RTL and testbench
===========================================

Name: sys_array_tile_scheduler

Overview:
- Sequences a fixed-size systolic array over a fully-connected layer larger than the array, e.g. 1x784 input by 784x10 weights on a 10x13 array.
- Walks the reduction dimension (K) in chunks of ARRAY_L and the output dimension (N) in chunks of ARRAY_W.
- Issues one tile command per chunk, accumulates partial sums, then adds bias and presents one result vector.
- Sits between the top-level wrapper (start/ready) and the array fetcher (tile_start/tile_done); feeds the argmax stage.

Parameters:
- DATA_WIDTH, 16, width of bias elements (signed).
- ACC_WIDTH, 32, width of partial sums, accumulators and results (signed).
- ARRAY_W, 10, output columns produced per tile.
- ARRAY_L, 13, reduction rows consumed per tile.
- ARRAY_A_L, 784, total reduction length K.
- ARRAY_W_L, 10, total output count N.
- IDX_W, 8, width of the tile index and length fields.
- Derived: K_TILES = ceil(ARRAY_A_L/ARRAY_L); N_TILES = ceil(ARRAY_W_L/ARRAY_W); K_LAST = ARRAY_A_L - (K_TILES-1)*ARRAY_L.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a full layer.
- busy  out  1  high from the cycle after an accepted start until DONE.
- tile_start  out  1  one-cycle pulse commanding the array to compute one tile.
- tile_k_idx  out  IDX_W  K chunk index of the current tile.
- tile_n_idx  out  IDX_W  N chunk index of the current tile.
- tile_k_len  out  IDX_W  valid reduction rows in this tile (ARRAY_L, or K_LAST on the final K chunk).
- tile_done  in  1  one-cycle pulse from the array; tile_result is valid in the same cycle.
- tile_result  in  ARRAY_W*ACC_WIDTH  signed partial sums; element i at bits [i*ACC_WIDTH +: ACC_WIDTH].
- bias  in  ARRAY_W_L*DATA_WIDTH  signed bias, packed the same way; held static by the source.
- result  out  ARRAY_W_L*ACC_WIDTH  signed layer output, accumulator plus bias.
- result_valid  out  1  one-cycle pulse when result updates.
- done  out  1  high from result_valid until the next accepted start.

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, tile_start, result_valid, done = 0; indices, tile_k_len = 0; result and all accumulators = 0.
- States: IDLE, ISSUE, WAIT, NEXT, BIAS, DONE.
- IDLE/DONE + start=1:
  - clear all ARRAY_W_L accumulators; k=0, n=0; busy=1; done=0; go to ISSUE.
  - start in any other state is ignored.
- ISSUE (1 cycle):
  - tile_start=1, with tile_k_idx=k, tile_n_idx=n, tile_k_len valid in the same cycle; go to WAIT.
  - Index and length outputs hold until the next ISSUE.
- WAIT:
  - On tile_done=1: for i in 0..ARRAY_W-1 with n*ARRAY_W+i < ARRAY_W_L, acc[n*ARRAY_W+i] += tile_result[i] at that edge; go to NEXT.
  - Out-of-range lanes are discarded.
  - tile_done outside WAIT is ignored, with no accumulator change.
- NEXT (1 cycle):
  - If k < K_TILES-1: k++, go to ISSUE.
  - Else if n < N_TILES-1: k=0, n++, go to ISSUE.
  - Else go to BIAS. Order is K inner, N outer.
- BIAS (1 cycle): result[j] = acc[j] + sign-extended bias[j] for all j; go to DONE.
- DONE entry: result_valid=1 for exactly 1 cycle; done=1, busy=0. Result holds until the next run's BIAS.
- Arithmetic: two's-complement, wraps modulo 2^ACC_WIDTH, no saturation.
- Latency: start to result_valid = 1 + sum over tiles of (2 + wait cycles) + 1 + 1 cycles.
- Reset mid-run: immediate abort to the reset values; no tile_start after release until a new start.
- start coincident with the tile_done of a running job: start ignored, tile_done processed normally.

Test Plan:
- Small config ARRAY_A_L=5, ARRAY_L=2, ARRAY_W=2, ARRAY_W_L=3 (K_TILES=3, N_TILES=2, K_LAST=1):
  - start -> six tile_start pulses in (k,n) order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - tile_k_len sequence 2,2,1,2,2,1.
- Same config, every tile_result lane = 10, bias = {-5,0,7} -> result = {25,30,37}, result_valid high exactly 1 cycle, done stays 1.
- tile_done held off 7 cycles per tile -> single tile_start per tile; busy stays 1; extra tile_done pulse in NEXT leaves accumulators unchanged.
- Second start after DONE, all partials = -1, bias 0 -> result = {-3,-3,-3}; no residue from run 1.
- reset_n low during WAIT of tile 3 -> all outputs 0 asynchronously; after release no tile_start until start.
- Default config, tile_result lanes = 0x7FFFFFFF on all 61 tiles -> wrapped sum 61*(2^31-1) mod 2^32 = 0x7FFFFFC3, i.e. +2147483587 (before bias).

Source files
------------

// File: rtl/sys_array_tile_scheduler.sv
// ---------------------------------------------------------------------------
// sys_array_tile_scheduler
//
// Runs a fully-connected layer (1 x ARRAY_A_L input times ARRAY_A_L x
// ARRAY_W_L weights) on a systolic array that only covers ARRAY_L reduction
// rows by ARRAY_W output columns per pass. The layer is cut into tiles: K is
// walked in chunks of ARRAY_L (inner loop), N in chunks of ARRAY_W (outer
// loop). Partial sums from each tile are accumulated per output. Bias is
// added once at the end and a single result vector is presented.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle request to run a layer (IDLE/DONE only)
//   busy                high while a layer is in flight
//   tile_start          one-cycle command to the array fetcher
//   tile_k_idx/n_idx    chunk indices of the commanded tile
//   tile_k_len          valid reduction rows in the commanded tile
//   tile_done           one-cycle completion pulse, tile_result valid with it
//   tile_result         ARRAY_W signed partial sums, lane i at [i*ACC_WIDTH +:]
//   bias                ARRAY_W_L signed bias values, static during a run
//   result              ARRAY_W_L signed outputs (accumulator + bias)
//   result_valid        one-cycle pulse when result updates
//   done                high from result_valid until the next accepted start
//   state_dbg           current FSM state encoding, for observation only
//
// Handshake: tile_start and tile_done are single-cycle pulses with no
// backpressure. Exactly one tile_start is issued per tile, and the next one
// is not issued until a tile_done has been seen in WAIT. tile_done in any
// other state is dropped. start is a pulse that is only honoured in IDLE or
// DONE; elsewhere it is dropped.
// ---------------------------------------------------------------------------
module sys_array_tile_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ARRAY_W    = 10,
  parameter int ARRAY_L    = 13,
  parameter int ARRAY_A_L  = 784,
  parameter int ARRAY_W_L  = 10,
  parameter int IDX_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            tile_start,
  output logic [IDX_W-1:0]                tile_k_idx,
  output logic [IDX_W-1:0]                tile_n_idx,
  output logic [IDX_W-1:0]                tile_k_len,
  input  logic                            tile_done,
  input  logic [ARRAY_W*ACC_WIDTH-1:0]    tile_result,
  input  logic [ARRAY_W_L*DATA_WIDTH-1:0] bias,
  output logic [ARRAY_W_L*ACC_WIDTH-1:0]  result,
  output logic                            result_valid,
  output logic                            done,
  output logic [2:0]                      state_dbg
);

  localparam int K_TILES = (ARRAY_A_L + ARRAY_L - 1) / ARRAY_L;
  localparam int N_TILES = (ARRAY_W_L + ARRAY_W - 1) / ARRAY_W;
  localparam int K_LAST  = ARRAY_A_L - (K_TILES - 1) * ARRAY_L;

  localparam logic [IDX_W-1:0] K_END    = IDX_W'(K_TILES - 1);
  localparam logic [IDX_W-1:0] N_END    = IDX_W'(N_TILES - 1);
  localparam logic [IDX_W-1:0] LEN_FULL = IDX_W'(ARRAY_L);
  localparam logic [IDX_W-1:0] LEN_LAST = IDX_W'(K_LAST);
  // Length of K chunk 0; a single-chunk layer starts on the short chunk.
  localparam logic [IDX_W-1:0] LEN_K0   = (K_TILES == 1) ? LEN_LAST : LEN_FULL;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_BIAS  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]     k_q, n_q, len_q;
  logic [ACC_WIDTH-1:0] acc_q [ARRAY_W_L];
  logic                 start_accept;

  assign start_accept = start && (state_q == S_IDLE || state_q == S_DONE);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tile_start = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        tile_start = 1'b1;
        busy       = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (tile_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        busy = 1'b1;
        if (k_q != K_END || n_q != N_END) state_d = S_ISSUE;
        else                              state_d = S_BIAS;
      end
      S_BIAS: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start_accept) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Tile indices, accumulators and result
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q          <= '0;
      n_q          <= '0;
      len_q        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      for (int j = 0; j < ARRAY_W_L; j++) acc_q[j] <= '0;
    end else begin
      // BIAS lasts one cycle, so this pulses on the first DONE cycle only.
      result_valid <= (state_q == S_BIAS);

      if (start_accept) begin
        k_q   <= '0;
        n_q   <= '0;
        len_q <= LEN_K0;
        for (int j = 0; j < ARRAY_W_L; j++) acc_q[j] <= '0;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (tile_done) begin
              // Output j belongs to N chunk j/ARRAY_W, lane j%ARRAY_W. Lanes
              // past ARRAY_W_L in the last N chunk have no output and are
              // simply never read.
              for (int j = 0; j < ARRAY_W_L; j++) begin
                if (n_q == IDX_W'(j / ARRAY_W)) begin
                  acc_q[j] <= acc_q[j] +
                              tile_result[(j % ARRAY_W)*ACC_WIDTH +: ACC_WIDTH];
                end
              end
            end
          end
          S_NEXT: begin
            if (k_q != K_END) begin
              k_q   <= k_q + IDX_W'(1);
              len_q <= ((k_q + IDX_W'(1)) == K_END) ? LEN_LAST : LEN_FULL;
            end else if (n_q != N_END) begin
              k_q   <= '0;
              n_q   <= n_q + IDX_W'(1);
              len_q <= LEN_K0;
            end
          end
          S_BIAS: begin
            for (int j = 0; j < ARRAY_W_L; j++) begin
              result[j*ACC_WIDTH +: ACC_WIDTH] <= acc_q[j] +
                {{(ACC_WIDTH-DATA_WIDTH){bias[j*DATA_WIDTH + DATA_WIDTH - 1]}},
                 bias[j*DATA_WIDTH +: DATA_WIDTH]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tile_k_idx = k_q;
  assign tile_n_idx = n_q;
  assign tile_k_len = len_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sys_array_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sys_array_tile_scheduler
//
// Two instances share clock and reset: a small configuration (K=5, L=2,
// W=2, N=3 -> 3x2 tiles, last K chunk of 1) for sequencing, bias and reset
// scenarios, and the default configuration (61 K tiles) for wrap-around.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sys_array_tile_scheduler;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // small instance
  logic        start_s = 1'b0;
  logic        busy_s, tile_start_s, result_valid_s, done_s;
  logic [7:0]  tile_k_idx_s, tile_n_idx_s, tile_k_len_s;
  logic        tile_done_s = 1'b0;
  logic [63:0] tile_result_s = '0;
  logic [47:0] bias_s = '0;
  logic [95:0] result_s;
  logic [2:0]  state_dbg_s;

  sys_array_tile_scheduler #(
    .DATA_WIDTH(16), .ACC_WIDTH(32), .ARRAY_W(2), .ARRAY_L(2),
    .ARRAY_A_L(5), .ARRAY_W_L(3), .IDX_W(8)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start_s), .busy(busy_s),
    .tile_start(tile_start_s), .tile_k_idx(tile_k_idx_s),
    .tile_n_idx(tile_n_idx_s), .tile_k_len(tile_k_len_s),
    .tile_done(tile_done_s), .tile_result(tile_result_s), .bias(bias_s),
    .result(result_s), .result_valid(result_valid_s), .done(done_s),
    .state_dbg(state_dbg_s)
  );

  // default instance
  logic         start_d = 1'b0;
  logic         busy_d, tile_start_d, result_valid_d, done_d;
  logic [7:0]   tile_k_idx_d, tile_n_idx_d, tile_k_len_d;
  logic         tile_done_d = 1'b0;
  logic [319:0] tile_result_d = '0;
  logic [159:0] bias_d = '0;
  logic [319:0] result_d;
  logic [2:0]   state_dbg_d;

  sys_array_tile_scheduler dut_d (
    .clk(clk), .reset_n(reset_n), .start(start_d), .busy(busy_d),
    .tile_start(tile_start_d), .tile_k_idx(tile_k_idx_d),
    .tile_n_idx(tile_n_idx_d), .tile_k_len(tile_k_len_d),
    .tile_done(tile_done_d), .tile_result(tile_result_d), .bias(bias_d),
    .result(result_d), .result_valid(result_valid_d), .done(done_d),
    .state_dbg(state_dbg_d)
  );

  // expected tile order for the small configuration
  int exp_k   [6] = '{0, 1, 2, 0, 1, 2};
  int exp_n   [6] = '{0, 0, 0, 1, 1, 1};
  int exp_len [6] = '{2, 2, 1, 2, 2, 1};

  // observations filled by the driver
  int obs_k [6];
  int obs_n [6];
  int obs_len [6];
  int obs_cnt;
  bit timed_out;
  int stray_starts;
  bit busy_dropped;

  // ---------------------------------------------------------------------------
  // Driver: run one layer on the small instance acting as the array.
  //   lane          value on every tile_result lane
  //   delay         extra WAIT cycles before tile_done
  //   extra         hold tile_done one more cycle so it lands in NEXT
  //   start_on_done raise start together with the first tile_done
  // ---------------------------------------------------------------------------
  task automatic drive_small(input logic [31:0] lane, input int delay,
                             input bit extra, input bit start_on_done);
    int c;
    obs_cnt = 0; timed_out = 1'b0; stray_starts = 0; busy_dropped = 1'b0;
    tile_result_s = {lane, lane};
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int t = 0; t < 6; t++) begin
      c = 0;
      while (tile_start_s !== 1'b1 && c < 50) begin
        @(negedge clk);
        c++;
      end
      if (c >= 50) begin
        timed_out = 1'b1;
        return;
      end
      obs_k[t] = int'(tile_k_idx_s);
      obs_n[t] = int'(tile_n_idx_s);
      obs_len[t] = int'(tile_k_len_s);
      obs_cnt++;
      @(negedge clk);
      for (int d = 0; d < delay; d++) begin
        if (tile_start_s) stray_starts++;
        if (!busy_s) busy_dropped = 1'b1;
        @(negedge clk);
      end
      tile_done_s = 1'b1;
      if (start_on_done && t == 0) start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      if (extra) @(negedge clk);
      tile_done_s = 1'b0;
    end
  endtask

  task automatic wait_result_s(output bit seen);
    int c;
    c = 0;
    while (result_valid_s !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    seen = (c < 20);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_s, tile_start_s, result_valid_s, done_s} !== 4'b0) begin
      errors++; $display("FAIL reset_flags_s: got %b want 0000",
                         {busy_s, tile_start_s, result_valid_s, done_s});
    end
    checks++;
    if ({tile_k_idx_s, tile_n_idx_s, tile_k_len_s} !== 24'd0 || result_s !== '0) begin
      errors++; $display("FAIL reset_data_s: idx/len %h result %h want 0",
                         {tile_k_idx_s, tile_n_idx_s, tile_k_len_s}, result_s);
    end
    checks++;
    if ({busy_d, tile_start_d, done_d} !== 3'b0 || result_d !== '0 || tile_k_len_d !== 8'd0) begin
      errors++; $display("FAIL reset_d: busy %b ts %b done %b len %0d result %h want 0",
                         busy_d, tile_start_d, done_d, tile_k_len_d, result_d);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sequence;
    bit seen;
    bias_s = {16'd7, 16'd0, 16'hFFFB};   // {7, 0, -5}, element 0 lowest
    drive_small(32'd10, 0, 1'b0, 1'b0);
    checks++;
    if (timed_out || obs_cnt != 6) begin
      errors++; $display("FAIL seq_tile_count: got %0d tiles (timeout %0b) want 6",
                         obs_cnt, timed_out);
    end
    for (int t = 0; t < obs_cnt; t++) begin
      checks++;
      if (obs_k[t] != exp_k[t] || obs_n[t] != exp_n[t] || obs_len[t] != exp_len[t]) begin
        errors++; $display("FAIL seq_tile%0d: got k=%0d n=%0d len=%0d want k=%0d n=%0d len=%0d",
                           t, obs_k[t], obs_n[t], obs_len[t], exp_k[t], exp_n[t], exp_len[t]);
      end
    end
    wait_result_s(seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL seq_result_valid: got none want pulse");
    end
    checks++;
    if (result_s !== {32'd37, 32'd30, 32'hFFFF_FFE7 + 32'd50}) begin
      errors++; $display("FAIL seq_result: got %h want {37,30,25}", result_s);
    end
    @(negedge clk);
    checks++;
    if (result_valid_s !== 1'b0 || done_s !== 1'b1 || busy_s !== 1'b0) begin
      errors++; $display("FAIL seq_after: rv %b done %b busy %b want 0 1 0",
                         result_valid_s, done_s, busy_s);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_s !== 1'b1 || result_s !== {32'd37, 32'd30, 32'd25}) begin
      errors++; $display("FAIL seq_hold: done %b result %h want 1 {37,30,25}", done_s, result_s);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hold_off;
    bit seen;
    drive_small(32'd10, 7, 1'b1, 1'b0);
    checks++;
    if (timed_out || obs_cnt != 6 || stray_starts != 0) begin
      errors++; $display("FAIL hold_tiles: got %0d tiles stray %0d want 6 stray 0",
                         obs_cnt, stray_starts);
    end
    checks++;
    if (busy_dropped) begin
      errors++; $display("FAIL hold_busy: got busy low during wait want high");
    end
    wait_result_s(seen);
    checks++;
    if (!seen || result_s !== {32'd37, 32'd30, 32'd25}) begin
      errors++; $display("FAIL hold_result: got %h (seen %0b) want {37,30,25}", result_s, seen);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back;
    bit seen;
    bias_s = '0;
    @(negedge clk);
    drive_small(32'hFFFF_FFFF, 0, 1'b0, 1'b1);
    checks++;
    if (timed_out || obs_cnt != 6) begin
      errors++; $display("FAIL b2b_tiles: got %0d want 6", obs_cnt);
    end
    wait_result_s(seen);
    checks++;
    if (!seen || result_s !== {3{32'hFFFF_FFFD}}) begin
      errors++; $display("FAIL b2b_result: got %h (seen %0b) want {-3,-3,-3}", result_s, seen);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mid_reset;
    int c;
    int starts_seen;
    bit busy_seen;
    tile_result_s = {32'd4, 32'd4};
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int t = 0; t < 3; t++) begin
      c = 0;
      while (tile_start_s !== 1'b1 && c < 50) begin
        @(negedge clk);
        c++;
      end
      @(negedge clk);               // now in WAIT of tile t
      if (t < 2) begin
        tile_done_s = 1'b1;
        @(negedge clk);
        tile_done_s = 1'b0;
      end
    end
    checks++;
    if (state_dbg_s !== 3'd2 || tile_k_idx_s !== 8'd2) begin
      errors++; $display("FAIL mreset_pre: state %0d k %0d want 2 2", state_dbg_s, tile_k_idx_s);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_s, tile_start_s, result_valid_s, done_s} !== 4'b0 || state_dbg_s !== 3'd0) begin
      errors++; $display("FAIL mreset_flags: got %b state %0d want 0000 0",
                         {busy_s, tile_start_s, result_valid_s, done_s}, state_dbg_s);
    end
    checks++;
    if ({tile_k_idx_s, tile_n_idx_s, tile_k_len_s} !== 24'd0 || result_s !== '0) begin
      errors++; $display("FAIL mreset_data: idx/len %h result %h want 0",
                         {tile_k_idx_s, tile_n_idx_s, tile_k_len_s}, result_s);
    end
    @(negedge clk);
    reset_n = 1'b1;
    starts_seen = 0; busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tile_start_s) starts_seen++;
      if (busy_s) busy_seen = 1'b1;
    end
    checks++;
    if (starts_seen != 0 || busy_seen) begin
      errors++; $display("FAIL mreset_idle: got %0d tile_start busy %0b want 0 0",
                         starts_seen, busy_seen);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap;
    int c;
    int tiles;
    int idx_bad;
    int first_len;
    int last_len;
    tile_result_d = {10{32'h7FFF_FFFF}};
    bias_d = '0;
    tiles = 0; idx_bad = 0; first_len = -1; last_len = -1;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    for (int t = 0; t < 61; t++) begin
      c = 0;
      while (tile_start_d !== 1'b1 && c < 50) begin
        @(negedge clk);
        c++;
      end
      if (c >= 50) break;
      tiles++;
      if (tile_k_idx_d !== 8'(t) || tile_n_idx_d !== 8'd0) idx_bad++;
      if (t == 0) first_len = int'(tile_k_len_d);
      if (t == 60) last_len = int'(tile_k_len_d);
      @(negedge clk);
      tile_done_d = 1'b1;
      @(negedge clk);
      tile_done_d = 1'b0;
    end
    checks++;
    if (tiles != 61 || idx_bad != 0) begin
      errors++; $display("FAIL wrap_tiles: got %0d tiles %0d bad idx want 61 0", tiles, idx_bad);
    end
    checks++;
    if (first_len != 13 || last_len != 4) begin
      errors++; $display("FAIL wrap_len: got first %0d last %0d want 13 4", first_len, last_len);
    end
    c = 0;
    while (result_valid_d !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= 20 || result_d !== {10{32'h7FFF_FFC3}}) begin
      errors++; $display("FAIL wrap_result: got %h want 10 x 7fffffc3", result_d);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_sequence();
    test_hold_off();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
